// File: rtl/csr_wr_arbiter_if.sv
// Bundles the requester-side and CSR-side signals of csr_wr_arbiter.
//   req/req_addr/req_data : per-requester write requests (flat, requester i at [i*W +: W])
//   ack/ack_err           : one-cycle completion pulse to the granted requester, err = timed out
//   csr_wr_*              : single write strobe + latched addr/data toward the CSR synchronizer,
//                           csr_wr_wait is the synchronizer busy back-pressure
//   busy/timeout_sticky   : status
// slave  : arbiter view. master : requesters + synchronizer view.
interface csr_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               ack_err;
  logic               csr_wr_strobe;
  logic [AW-1:0]      csr_wr_addr;
  logic [DW-1:0]      csr_wr_data;
  logic               csr_wr_wait;
  logic               busy;
  logic               timeout_sticky;

  modport slave (
    input  req, req_addr, req_data, csr_wr_wait,
    output ack, ack_err, csr_wr_strobe, csr_wr_addr, csr_wr_data, busy, timeout_sticky
  );

  modport master (
    output req, req_addr, req_data, csr_wr_wait,
    input  ack, ack_err, csr_wr_strobe, csr_wr_addr, csr_wr_data, busy, timeout_sticky
  );
endinterface

// File: rtl/csr_wr_arbiter.sv
// Round-robin arbiter funnelling NREQ CSR write requesters into one CSR
// synchronizer port. Each transaction walks IDLE -> STROBE -> HOLD -> ACK:
// the winner's addr/data are latched in IDLE, a single strobe is issued,
// the FSM waits for csr_wr_wait to drop (or abandons after TIMEOUT HOLD
// cycles), then pulses ack to the winner.
// Ports: clk, rst_b (async active low), bus (csr_wr_arbiter_if.slave).
// All outputs are registered.
module csr_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_b,
  csr_wr_arbiter_if.slave  bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, STROBE, HOLD, ACK} state_t;

  state_t          state;
  logic [GW-1:0]   grant, last_grant;
  logic [15:0]     cnt;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q, strobe_q, busy_q, sticky_q;

  // Round-robin pick: first requesting index scanning up from last_grant+1.
  logic [GW-1:0]   win, idx;
  logic            found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last_grant) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);  // so requester 0 wins the first arbitration
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      // pulse outputs default low; only the transitions below raise them
      strobe_q <= 1'b0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= win;
            addr_q   <= bus.req_addr[win*AW +: AW];
            data_q   <= bus.req_data[win*DW +: DW];
            strobe_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= STROBE;
          end
        end
        STROBE: begin
          // csr_wr_wait is not looked at here; the synchronizer may still
          // report busy from the strobe cycle itself.
          cnt   <= '0;
          state <= HOLD;
        end
        HOLD: begin
          if (!bus.csr_wr_wait) begin
            ack_q <= NREQ'(1) << grant;
            state <= ACK;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            // TIMEOUT-th HOLD cycle still stalled: abandon the write
            ack_q    <= NREQ'(1) << grant;
            err_q    <= 1'b1;
            sticky_q <= 1'b1;
            state    <= ACK;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ACK: begin
          last_grant <= grant;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack            = ack_q;
  assign bus.ack_err        = err_q;
  assign bus.csr_wr_strobe  = strobe_q;
  assign bus.csr_wr_addr    = addr_q;
  assign bus.csr_wr_data    = data_q;
  assign bus.busy           = busy_q;
  assign bus.timeout_sticky = sticky_q;
endmodule

// File: tb/tb_csr_wr_arbiter.sv
// Directed bench for csr_wr_arbiter. Two instances share clk/rst_b:
// dA uses the default TIMEOUT, dB uses TIMEOUT=4 for the abandon case.
// Stimulus pushes expected strobes/acks into queues; per-instance monitors
// pop and compare them whenever the DUT emits a strobe or an ack.
module tb_csr_wr_arbiter;
  logic clk = 1'b0;
  logic rst_b;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csr_wr_arbiter_if #(.NREQ(4), .AW(8), .DW(32)) bA ();
  csr_wr_arbiter_if #(.NREQ(4), .AW(8), .DW(32)) bB ();

  csr_wr_arbiter #(.NREQ(4), .AW(8), .DW(32)) dA (.clk(clk), .rst_b(rst_b), .bus(bA));
  csr_wr_arbiter #(.NREQ(4), .AW(8), .DW(32), .TIMEOUT(4)) dB (.clk(clk), .rst_b(rst_b), .bus(bB));

  typedef struct { logic [7:0] addr; logic [31:0] data; int cyc; } stb_t;
  typedef struct { logic [3:0] ack; logic err; logic [7:0] addr; logic [31:0] data; int cyc; } ack_t;

  stb_t qsA[$], qsB[$];
  ack_t qaA[$], qaB[$];
  stb_t sA, sB;
  ack_t aA, aB;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_b) begin
      if (bA.csr_wr_strobe) begin
        if (qsA.size() == 0) chk("A_spurious_strobe", 32'(bA.csr_wr_strobe), 0);
        else begin
          sA = qsA.pop_front();
          chk("A_strobe_addr", 32'(bA.csr_wr_addr), 32'(sA.addr));
          chk("A_strobe_data", bA.csr_wr_data, sA.data);
          if (sA.cyc >= 0) chk("A_strobe_cyc", cyc, sA.cyc);
        end
      end
      if (|bA.ack) begin
        if (qaA.size() == 0) chk("A_spurious_ack", 32'(bA.ack), 0);
        else begin
          aA = qaA.pop_front();
          chk("A_ack_vec", 32'(bA.ack), 32'(aA.ack));
          chk("A_ack_err", 32'(bA.ack_err), 32'(aA.err));
          chk("A_ack_addr", 32'(bA.csr_wr_addr), 32'(aA.addr));
          chk("A_ack_data", bA.csr_wr_data, aA.data);
          if (aA.cyc >= 0) chk("A_ack_cyc", cyc, aA.cyc);
        end
      end else chk("A_err_without_ack", 32'(bA.ack_err), 0);
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      if (bB.csr_wr_strobe) begin
        if (qsB.size() == 0) chk("B_spurious_strobe", 32'(bB.csr_wr_strobe), 0);
        else begin
          sB = qsB.pop_front();
          chk("B_strobe_addr", 32'(bB.csr_wr_addr), 32'(sB.addr));
          chk("B_strobe_data", bB.csr_wr_data, sB.data);
          if (sB.cyc >= 0) chk("B_strobe_cyc", cyc, sB.cyc);
        end
      end
      if (|bB.ack) begin
        if (qaB.size() == 0) chk("B_spurious_ack", 32'(bB.ack), 0);
        else begin
          aB = qaB.pop_front();
          chk("B_ack_vec", 32'(bB.ack), 32'(aB.ack));
          chk("B_ack_err", 32'(bB.ack_err), 32'(aB.err));
          chk("B_ack_addr", 32'(bB.csr_wr_addr), 32'(aB.addr));
          chk("B_ack_data", bB.csr_wr_data, aB.data);
          if (aB.cyc >= 0) chk("B_ack_cyc", cyc, aB.cyc);
        end
      end else chk("B_err_without_ack", 32'(bB.ack_err), 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ack(input bit use_b);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      hit = use_b ? |bB.ack : |bA.ack;
    end
    chk(use_b ? "B_ack_arrived" : "A_ack_arrived", 32'(hit), 1);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_ack"},    32'(bA.ack), 0);
    chk({tag, "_err"},    32'(bA.ack_err), 0);
    chk({tag, "_strobe"}, 32'(bA.csr_wr_strobe), 0);
    chk({tag, "_addr"},   32'(bA.csr_wr_addr), 0);
    chk({tag, "_data"},   bA.csr_wr_data, 0);
    chk({tag, "_busy"},   32'(bA.busy), 0);
    chk({tag, "_sticky"}, 32'(bA.timeout_sticky), 0);
  endtask

  function automatic stb_t mk_s(input logic [7:0] a, input logic [31:0] d, input int c);
    stb_t s;
    s.addr = a; s.data = d; s.cyc = c;
    return s;
  endfunction

  function automatic ack_t mk_a(input logic [3:0] v, input logic e, input logic [7:0] a,
                                input logic [31:0] d, input int c);
    ack_t r;
    r.ack = v; r.err = e; r.addr = a; r.data = d; r.cyc = c;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  int c0;
  int seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst_b = 1'b0;
    bA.req = '0; bA.req_addr = '0; bA.req_data = '0; bA.csr_wr_wait = 1'b0;
    bB.req = '0; bB.req_addr = '0; bB.req_data = '0; bB.csr_wr_wait = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_a("rst");
    chk("rst_B_sticky", 32'(bB.timeout_sticky), 0);
    chk("rst_B_busy", 32'(bB.busy), 0);
    rst_b = 1'b1;
    @(negedge clk);

    // single write, no wait; later addr/data changes must not leak through
    bA.req_addr[7:0]  = 8'h12;
    bA.req_data[31:0] = 32'hDEADBEEF;
    c0 = cyc;
    qsA.push_back(mk_s(8'h12, 32'hDEADBEEF, c0 + 1));
    qaA.push_back(mk_a(4'b0001, 1'b0, 8'h12, 32'hDEADBEEF, c0 + 3));
    bA.req = 4'b0001;
    @(negedge clk);
    chk("single_busy", 32'(bA.busy), 1);
    bA.req_addr[7:0]  = 8'hFF;
    bA.req_data[31:0] = 32'h0;
    wait_ack(1'b0);
    bA.req = '0;
    @(negedge clk);
    chk("single_idle_busy", 32'(bA.busy), 0);

    // wait stretch: five stalled HOLD cycles, ack one cycle after wait falls
    bA.req_addr[15:8]  = 8'h34;
    bA.req_data[63:32] = 32'hCAFEF00D;
    bA.csr_wr_wait = 1'b1;
    c0 = cyc;
    qsA.push_back(mk_s(8'h34, 32'hCAFEF00D, c0 + 1));
    qaA.push_back(mk_a(4'b0010, 1'b0, 8'h34, 32'hCAFEF00D, c0 + 8));
    bA.req = 4'b0010;
    repeat (7) @(negedge clk);
    bA.csr_wr_wait = 1'b0;
    wait_ack(1'b0);
    bA.req = '0;
    @(negedge clk);

    // round robin from reset: 0,1,2,3,0,1,2 then req=1001 -> 3
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bA.req_addr[i*8 +: 8]   = 8'(8'h40 + i);
      bA.req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    for (int k = 0; k < 8; k++) begin
      qsA.push_back(mk_s(8'(8'h40 + seq[k]), 32'hA000_0000 + 32'(seq[k]), -1));
      qaA.push_back(mk_a(4'(1 << seq[k]), 1'b0, 8'(8'h40 + seq[k]),
                         32'hA000_0000 + 32'(seq[k]), -1));
    end
    bA.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_ack(1'b0);
      if (k == 6) bA.req = 4'b1001;
      if (k == 7) bA.req = 4'b0000;
    end
    @(negedge clk);
    chk("rr_queue_empty", 32'(qaA.size()), 0);

    // reset in the middle of HOLD: outputs clear at once, no ack
    bA.req_addr[23:16] = 8'h56;
    bA.req_data[95:64] = 32'h12345678;
    bA.csr_wr_wait = 1'b1;
    c0 = cyc;
    qsA.push_back(mk_s(8'h56, 32'h12345678, c0 + 1));
    bA.req = 4'b0100;
    repeat (3) @(negedge clk);
    chk("midrst_busy_hold", 32'(bA.busy), 1);
    #2 rst_b = 1'b0;
    #1 chk_zero_a("midrst");
    bA.req = '0;
    bA.csr_wr_wait = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    qsA.push_back(mk_s(8'h56, 32'h12345678, -1));
    qaA.push_back(mk_a(4'b0100, 1'b0, 8'h56, 32'h12345678, -1));
    bA.req = 4'b0100;
    wait_ack(1'b0);
    bA.req = '0;
    repeat (3) @(negedge clk);
    chk("A_strobe_queue_empty", 32'(qsA.size()), 0);
    chk("A_ack_queue_empty", 32'(qaA.size()), 0);

    // timeout on instance B (TIMEOUT=4): ack_err after four HOLD cycles
    bB.req_addr[7:0]  = 8'h77;
    bB.req_data[31:0] = 32'h0BADF00D;
    bB.csr_wr_wait = 1'b1;
    c0 = cyc;
    qsB.push_back(mk_s(8'h77, 32'h0BADF00D, c0 + 1));
    qaB.push_back(mk_a(4'b0001, 1'b1, 8'h77, 32'h0BADF00D, c0 + 6));
    bB.req = 4'b0001;
    wait_ack(1'b1);
    bB.req = '0;
    chk("B_sticky_at_ack", 32'(bB.timeout_sticky), 1);
    repeat (3) @(negedge clk);
    chk("B_sticky_held", 32'(bB.timeout_sticky), 1);
    chk("B_idle_busy", 32'(bB.busy), 0);
    chk("B_queue_empty", 32'(qaB.size() + qsB.size()), 0);
    bB.csr_wr_wait = 1'b0;
    rst_b = 1'b0;
    #1 chk("B_sticky_reset", 32'(bB.timeout_sticky), 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
